// File: rtl/led_fan_pkg.sv
// Shared definitions for the LED fan datapath: scheduler state encoding,
// column-index width helper and default geometry constants.
package led_fan_pkg;

  localparam int DEFAULT_NUM_COLS   = 64;
  localparam int DEFAULT_CNT_W      = 26;
  localparam int DEFAULT_MIN_PERIOD = 4096;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE,
    RUN
  } sched_state_t;

  function automatic int col_w(input int num_cols);
    return $clog2(num_cols);
  endfunction

endpackage

// File: rtl/rev_period_counter.sv
// Saturating revolution-period counter with glitch rejection of short index
// periods and a timeout flag raised on the cycle the counter saturates.
module rev_period_counter #(
  parameter int CNT_W      = 26,
  parameter int MIN_PERIOD = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             force_accept,
  input  logic             index_pulse,
  output logic             accept,
  output logic [CNT_W-1:0] period,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_LIMIT = CNT_W'(MIN_PERIOD);

  logic [CNT_W-1:0] pcnt_reg;

  // The cycles between two accepted indices include the clearing cycle.
  assign period  = pcnt_reg + ONE;
  assign accept  = index_pulse && !clear && (force_accept || (period >= MIN_LIMIT));
  // Flag the step into saturation so the owner can react on that same edge.
  assign timeout = !clear && !accept && (pcnt_reg == CNT_MAX - ONE);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pcnt_reg <= '0;
    end else if (accept) begin
      pcnt_reg <= '0;
    end else if (pcnt_reg != CNT_MAX) begin
      pcnt_reg <= pcnt_reg + ONE;
    end
  end

endmodule

// File: rtl/pov_column_scheduler.sv
// Splits each measured fan revolution into NUM_COLS equal slots and issues a
// registered column strobe plus column index at the start of every slot.
module pov_column_scheduler
  import led_fan_pkg::*;
#(
  parameter int NUM_COLS   = DEFAULT_NUM_COLS,
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       index_pulse,
  output logic                       col_strobe,
  output logic [col_w(NUM_COLS)-1:0] col_idx,
  output logic                       locked,
  output logic                       period_err
);

  localparam int               COL_W    = col_w(NUM_COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  sched_state_t     state_reg;
  logic [CNT_W-1:0] slot_len_reg;
  logic [CNT_W-1:0] scnt_reg;
  logic [CNT_W-1:0] shifted_len;
  logic [CNT_W-1:0] slot_len_next;
  logic [CNT_W-1:0] period;
  logic             accept;
  logic             timeout;

  rev_period_counter #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_period (
    .clk          (clk),
    .rst          (rst),
    .clear        (state_reg == IDLE),
    .force_accept (state_reg == ARMED),
    .index_pulse  (index_pulse),
    .accept       (accept),
    .period       (period),
    .timeout      (timeout)
  );

  // Remainder is dropped; a zero-length slot would stall the slot counter.
  assign shifted_len   = period >> COL_W;
  assign slot_len_next = (shifted_len == '0) ? ONE : shifted_len;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_reg    <= IDLE;
      slot_len_reg <= '0;
      scnt_reg     <= '0;
      col_strobe   <= 1'b0;
      col_idx      <= '0;
      locked       <= 1'b0;
      period_err   <= 1'b0;
    end else begin
      col_strobe <= 1'b0;
      period_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          state_reg <= ARMED;
        end
        ARMED: begin
          if (accept) begin
            state_reg <= MEASURE;
          end
        end
        MEASURE, RUN: begin
          // An accepted index wins over a coinciding slot wrap.
          if (accept) begin
            state_reg    <= RUN;
            slot_len_reg <= slot_len_next;
            scnt_reg     <= '0;
            col_idx      <= '0;
            col_strobe   <= 1'b1;
            locked       <= 1'b1;
          end else if (timeout) begin
            state_reg  <= ARMED;
            scnt_reg   <= '0;
            col_idx    <= '0;
            locked     <= 1'b0;
            period_err <= 1'b1;
          end else if (state_reg == RUN && col_idx != COL_LAST) begin
            if (scnt_reg == slot_len_reg - ONE) begin
              scnt_reg   <= '0;
              col_idx    <= col_idx + COL_ONE;
              col_strobe <= 1'b1;
            end else begin
              scnt_reg <= scnt_reg + ONE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pov_column_scheduler.md
# pov_column_scheduler

Sequences column output for the rotating LED fan. It measures the revolution period from a one-cycle index pulse, splits each revolution into `NUM_COLS` equal time slots, and issues one column strobe plus a column index per slot. `output_generater` uses the strobe and index to pick which 16-bit column pattern drives `led`. It sits between the debounced/one-pulsed index sensor and the output generator, in the `clk` domain.

## Interface
- `NUM_COLS`, 64: columns per revolution. Must be a power of two, ≥ 2.
- `CNT_W`, 26: period counter width. The longest valid revolution is 2^CNT_W − 1 cycles.
- `MIN_PERIOD`, 4096: shortest accepted period in cycles. Must be ≥ `NUM_COLS`.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: scheduler enable. Level-sensitive.
- `index_pulse`, in, 1: one-cycle pulse, once per revolution. Already debounced and one-pulsed.
- `col_strobe`, out, 1: one-cycle pulse that starts a column slot.
- `col_idx`, out, log2(NUM_COLS): current column. Valid whenever `locked`=1.
- `locked`, out, 1: a period measurement is valid and columns are being scheduled.
- `period_err`, out, 1: one-cycle pulse on period-counter timeout.

## Operation
- FSM states: IDLE, ARMED, MEASURE, RUN.
- Reset and `en`=0:
  - `rst`=1, or `en`=0 in any state, forces IDLE in the next cycle.
  - In IDLE every output is 0, and both counters and `slot_len` are cleared.
- IDLE → ARMED on the cycle after `en`=1.
- Period counter `pcnt` (CNT_W bits):
  - Cleared in the cycle of an accepted index, then increments every cycle.
  - Saturates at 2^CNT_W − 1.
- Measured period = cycles between two accepted index pulses, i.e. `pcnt`+1 at the accepting edge.
- ARMED:
  - The first `index_pulse` is always accepted. Go to MEASURE and clear `pcnt`.
- Index acceptance in MEASURE and RUN:
  - An index whose period is < `MIN_PERIOD` is a glitch and is ignored. State, `pcnt`, slots and outputs are unaffected.
- Timeout:
  - When `pcnt` reaches saturation in MEASURE or RUN: `period_err` pulses, `locked`←0, state → ARMED, and strobes stop.
- MEASURE:
  - Accepted index: `slot_len` ← period >> log2(NUM_COLS), truncated with remainder discarded, never 0. Then go to RUN.
  - The next cycle has `col_strobe`=1, `col_idx`=0, `locked`=1.
- RUN:
  - Slot counter `scnt` counts 0..`slot_len`−1. At wrap, strobe and set `col_idx`+1.
  - After column `NUM_COLS`−1 has strobed, no further strobes. `col_idx` holds `NUM_COLS`−1 until the next accepted index.
  - Accepted index: reload `slot_len` from the new period, restart `scnt`, and strobe column 0 in the next cycle.
  - An index in the same cycle as a slot wrap takes priority. The pending strobe for the next column is dropped.

## Timing
- Latency from accepted index (cycle t) to column-0 strobe: 1 cycle, at t+1.
- Strobe for column k in a revolution: t+1+k·`slot_len`, for k < `NUM_COLS`.
- `period_err` occurs at t0+2^CNT_W, where t0 is the last accepted index.
- `locked` timing:
  - Rises together with the first column-0 strobe.
  - Falls in the same cycle as `period_err`, or the cycle after `en`/`rst` drops it.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Package `led_fan_pkg` holds:
  - the FSM state encoding (IDLE, ARMED, MEASURE, RUN);
  - the `COL_W` = log2(NUM_COLS) helper;
  - the default `NUM_COLS`, `CNT_W` and `MIN_PERIOD` constants, shared with `output_generater`.
- One sub-module, `rev_period_counter`. It owns the saturating counter, the `MIN_PERIOD` glitch check and the timeout flag, and outputs `accept`, `period` and `timeout`.
- The FSM and slot counter stay in the top of this block.

## Test plan
All scenarios use `NUM_COLS`=8, `CNT_W`=12, `MIN_PERIOD`=16, `en`=1 from cycle 10.
- Reset check: hold `rst` for 5 cycles, with `index_pulse` toggling. → `col_strobe`=0, `col_idx`=0, `locked`=0, `period_err`=0 throughout.
- Steady rotation: index at cycles 100, 180, 260. → Period 80, `slot_len`=10. Strobes at 181, 191, …, 251 for `col_idx` 0..7, then column 0 at 261. `locked` rises at 181.
- Glitch rejection: as the steady case, plus an extra index at 185. → Ignored (period 5 < 16). The strobe schedule is identical to the steady case.
- Slowdown: index at 100, 180, 300. → Columns 0..7 at 181..251, then no strobe in 252..300 with `col_idx` holding 7. Column 0 at 301, next strobe at 316 (`slot_len`=15).
- Timeout: index at 100, 180, then none. → `period_err` pulse and `locked`←0 at 4276. No strobes after that. A subsequent index only re-arms the block.
- Disable mid-run: `en`=0 at cycle 200 during steady rotation. → All outputs 0 from 201. Re-enable requires two accepted index pulses before the next strobe.
